fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and drives the synchronous ROM address from next-PC.
// Optional build macro FETCH_PERF_EN adds a 32-bit fetch_count output.
//
// state | meaning
// BOOT  | reset state; next fetch is RESET_PC
// RUN   | fetching, one instruction per cycle
// HALT  | misaligned redirect seen; PC frozen until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [9:0]  rom_addr,
  input  logic [31:0] rom_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // Redirect outranks stall; a misaligned target freezes the PC and halts.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    case (state_q)
      BOOT: begin
        pc_d    = RESET_PC;
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d = redirect_pc;
          end else begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      HALT: ;
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // PCs above the ROM size alias silently.
  assign rom_addr     = pc_d[11:2];
  assign if_pc        = pc_q;
  assign if_valid     = (state_q == RUN) && !err_q;
  assign if_instr     = if_valid ? rom_instr : NOP_INSTR;
  assign misalign_err = err_q;

`ifdef FETCH_PERF_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else if (if_valid && (!stall || redirect)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table through a scoreboard queue plus
// hand-written reset, misalign-halt and ROM-alias sequences.
module tb_fetch_unit;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        eerr;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [9:0]  rom_addr;
  logic [31:0] rom_q;
  logic [31:0] if_pc, if_instr;
  logic        if_valid, misalign_err;
  logic [31:0] fetch_count;

  logic        rst2_n = 1'b0;
  logic        zero_b = 1'b0;
  logic [31:0] zero_w = 32'd0;
  logic [9:0]  rom_addr2;
  logic [31:0] rom2_q;
  logic [31:0] if_pc2, if_instr2;
  logic        if_valid2, misalign_err2;
  logic [31:0] fetch_count2;

  int errors = 0;
  int checks = 0;
  int m_cnt = 0;
  logic m_valid = 1'b0;
  vec_t sbq[$];
  vec_t vec[15];

  always #5 clk = ~clk;

  // ROM with word i holding value i, one-cycle registered read.
  always @(posedge clk) rom_q  <= {22'd0, rom_addr};
  always @(posedge clk) rom2_q <= {22'd0, rom_addr2};

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_instr(rom_q),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count)
`endif
  );

  fetch_unit #(.RESET_PC(32'h0000_0FFC)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .stall(zero_b), .redirect(zero_b),
    .redirect_pc(zero_w), .rom_addr(rom_addr2), .rom_instr(rom2_q),
    .if_pc(if_pc2), .if_instr(if_instr2), .if_valid(if_valid2),
    .misalign_err(misalign_err2)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count2)
`endif
  );

`ifndef FETCH_PERF_EN
  assign fetch_count  = 32'd0;
  assign fetch_count2 = 32'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_count(input string name);
`ifdef FETCH_PERF_EN
    chk(name, fetch_count, m_cnt);
`endif
  endtask

  task automatic cyc(input vec_t v);
    vec_t e;
    stall       = v.st;
    redirect    = v.rd;
    redirect_pc = v.rpc;
    if (m_valid && (!v.st || v.rd)) m_cnt++;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("if_valid", {31'd0, if_valid}, {31'd0, e.ev});
    chk("if_pc", if_pc, e.epc);
    chk("if_instr", if_instr, e.einstr);
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.eerr});
    chk_count("fetch_count");
    m_valid = e.ev;
  endtask

  function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic ev,
                              logic [31:0] epc, logic [31:0] einstr, logic eerr);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.eerr = eerr;
    return v;
  endfunction

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    m_cnt   = 0;
    chk("rst if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst if_pc", if_pc, 32'd0);
    chk("rst if_instr", if_instr, NOP);
    chk("rst misalign_err", {31'd0, misalign_err}, 32'd0);
    chk("rst rom_addr", {22'd0, rom_addr}, 32'd0);
    chk_count("rst fetch_count");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Boot ignores stall/redirect, even a misaligned one.
    vec[0]  = mk(1, 1, 32'h102,      1, 32'h0,        32'h0,   0);
    vec[1]  = mk(0, 0, 32'h0,        1, 32'h4,        32'h1,   0);
    vec[2]  = mk(0, 0, 32'h0,        1, 32'h8,        32'h2,   0);
    vec[3]  = mk(0, 0, 32'h0,        1, 32'hC,        32'h3,   0);
    vec[4]  = mk(0, 0, 32'h0,        1, 32'h10,       32'h4,   0);
    vec[5]  = mk(1, 0, 32'h0,        1, 32'h10,       32'h4,   0);
    vec[6]  = mk(1, 0, 32'h0,        1, 32'h10,       32'h4,   0);
    vec[7]  = mk(1, 0, 32'h0,        1, 32'h10,       32'h4,   0);
    vec[8]  = mk(0, 0, 32'h0,        1, 32'h14,       32'h5,   0);
    vec[9]  = mk(1, 1, 32'h200,      1, 32'h200,      32'h80,  0);
    vec[10] = mk(0, 0, 32'h0,        1, 32'h204,      32'h81,  0);
    vec[11] = mk(0, 1, 32'hFFFF_FFFC,1, 32'hFFFF_FFFC,32'h3FF, 0);
    vec[12] = mk(0, 0, 32'h0,        1, 32'h0,        32'h0,   0);
    vec[13] = mk(0, 1, 32'h3C,       1, 32'h3C,       32'hF,   0);
    vec[14] = mk(0, 0, 32'h0,        1, 32'h40,       32'h10,  0);

    #2;
    chk("init if_valid", {31'd0, if_valid}, 32'd0);
    chk("init if_pc", if_pc, 32'd0);
    chk("init if_instr", if_instr, NOP);
    chk("init misalign_err", {31'd0, misalign_err}, 32'd0);
    chk("init rom_addr", {22'd0, rom_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) cyc(vec[i]);
    chk("free rom_addr", {22'd0, rom_addr}, 32'h11);

    // Reset mid-run at if_pc=0x40, then reboot and free-run three cycles.
    pulse_reset();
    cyc(mk(0, 0, 32'h0, 1, 32'h0, 32'h0, 0));
    cyc(mk(0, 0, 32'h0, 1, 32'h4, 32'h1, 0));
    cyc(mk(0, 0, 32'h0, 1, 32'h8, 32'h2, 0));
    cyc(mk(0, 0, 32'h0, 1, 32'hC, 32'h3, 0));

    // Misaligned redirect halts with PC frozen until reset.
    cyc(mk(0, 1, 32'h102, 0, 32'hC, NOP, 1));
    cyc(mk(0, 1, 32'h200, 0, 32'hC, NOP, 1));
    cyc(mk(1, 0, 32'h0,   0, 32'hC, NOP, 1));
    cyc(mk(0, 0, 32'h0,   0, 32'hC, NOP, 1));
    chk("halt rom_addr", {22'd0, rom_addr}, 32'h3);
    pulse_reset();
    cyc(mk(0, 0, 32'h0, 1, 32'h0, 32'h0, 0));
    cyc(mk(0, 0, 32'h0, 1, 32'h4, 32'h1, 0));

    // Second instance with RESET_PC=0xFFC: crossing 0x1000 aliases to ROM word 0.
    chk("alias rst rom_addr", {22'd0, rom_addr2}, 32'h3FF);
    chk("alias rst if_pc", if_pc2, 32'hFFC);
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    chk("alias boot if_valid", {31'd0, if_valid2}, 32'd1);
    chk("alias boot if_pc", if_pc2, 32'hFFC);
    chk("alias boot if_instr", if_instr2, 32'h3FF);
    chk("alias rom_addr", {22'd0, rom_addr2}, 32'h0);
    @(posedge clk);
    #1;
    chk("alias if_pc", if_pc2, 32'h1000);
    chk("alias if_instr", if_instr2, 32'h0);
    chk("alias misalign_err", {31'd0, misalign_err2}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("alias fetch_count", fetch_count2, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
